// File: rtl/smp_snoop_bus_arbiter.sv
// Snooping-bus arbiter for a two-core SMP: grants one cache controller at a time,
// broadcasts its bus op, then sequences snoop, optional flush and memory access.
module smp_snoop_bus_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [1:0]        type0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              req1,
    input  logic [1:0]        type1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt0,
    output logic              gnt1,
    output logic [2:0]        bus_op,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              snoop_wb,
    input  logic              flush_done,
    output logic              mem_req,
    input  logic              mem_rdy,
    output logic              done0,
    output logic              done1,
    output logic              err
);

    localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

    localparam logic [1:0] REQ_READ  = 2'd0;
    localparam logic [1:0] REQ_WRITE = 2'd1;
    localparam logic [1:0] REQ_INV   = 2'd2;
    localparam logic [1:0] REQ_RSVD  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        SNOOP,
        WAIT_FLUSH,
        MEM,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        NOOP         = 3'd0,
        READ_MISS_0  = 3'd1,
        READ_MISS_1  = 3'd2,
        WRITE_MISS_0 = 3'd3,
        WRITE_MISS_1 = 3'd4,
        INVALIDATE   = 3'd5
    } bus_op_t;

    state_t            state;
    logic              last_gnt;
    logic              owner;
    logic [1:0]        own_type;
    logic [CNT_W-1:0]  tcnt;

    logic              valid0;
    logic              valid1;
    logic              pick1;
    logic [1:0]        sel_type;

    // Reserved type 3 is treated as no request; ties go to the core not granted last.
    assign valid0   = req0 && (type0 != REQ_RSVD);
    assign valid1   = req1 && (type1 != REQ_RSVD);
    assign pick1    = valid1 && (!valid0 || !last_gnt);
    assign sel_type = pick1 ? type1 : type0;

    function automatic logic [2:0] map_op(input logic core, input logic [1:0] t);
        logic [2:0] op;
        op = NOOP;
        case (t)
            REQ_READ:  op = core ? READ_MISS_1  : READ_MISS_0;
            REQ_WRITE: op = core ? WRITE_MISS_1 : WRITE_MISS_0;
            REQ_INV:   op = INVALIDATE;
            default:   op = NOOP;
        endcase
        return op;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            bus_op   <= NOOP;
            bus_addr <= '0;
            mem_req  <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            err      <= 1'b0;
            last_gnt <= 1'b1;
            owner    <= 1'b0;
            own_type <= REQ_READ;
            tcnt     <= '0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid0 || valid1) begin
                        owner    <= pick1;
                        own_type <= sel_type;
                        last_gnt <= pick1;
                        gnt0     <= !pick1;
                        gnt1     <= pick1;
                        bus_op   <= map_op(pick1, sel_type);
                        bus_addr <= pick1 ? addr1 : addr0;
                        state    <= SNOOP;
                    end
                end
                SNOOP: begin
                    if (snoop_wb) begin
                        state <= WAIT_FLUSH;
                    end else if (own_type == REQ_INV) begin
                        state <= DONE;
                        done0 <= !owner;
                        done1 <= owner;
                    end else begin
                        state   <= MEM;
                        mem_req <= 1'b1;
                        tcnt    <= '0;
                    end
                end
                WAIT_FLUSH: begin
                    if (flush_done) begin
                        if (own_type == REQ_INV) begin
                            state <= DONE;
                            done0 <= !owner;
                            done1 <= owner;
                        end else begin
                            state   <= MEM;
                            mem_req <= 1'b1;
                            tcnt    <= '0;
                        end
                    end
                end
                MEM: begin
                    // A response arriving on the timeout cycle still counts as success.
                    if (mem_rdy) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        done0   <= !owner;
                        done1   <= owner;
                    end else if (tcnt == CNT_W'(MEM_TIMEOUT - 1)) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        done0   <= !owner;
                        done1   <= owner;
                        err     <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    gnt0   <= 1'b0;
                    gnt1   <= 1'b0;
                    bus_op <= NOOP;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
